// File: rtl/riscv_pkg.sv
// Shared RV32I encoding types and constants, also used by the decoder.
package riscv_pkg;

  typedef enum logic [3:0] {
    ENC_R, ENC_I, ENC_LOAD, ENC_STORE, ENC_BRANCH,
    ENC_JAL, ENC_JALR, ENC_LUI, ENC_AUIPC, ENC_LI
  } enc_op_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;
  localparam logic [2:0] F3_BEQ     = 3'd0;
  localparam logic [2:0] F3_BNE     = 3'd1;
  localparam logic [2:0] F3_BLT     = 3'd4;
  localparam logic [2:0] F3_BGE     = 3'd5;
  localparam logic [2:0] F3_BLTU    = 3'd6;
  localparam logic [2:0] F3_BGEU    = 3'd7;
  localparam logic [2:0] F3_JALR    = 3'd0;

  function automatic logic [2:0] alu_funct3(input alu_op_t op);
    case (op)
      ALU_ADD, ALU_SUB: alu_funct3 = F3_ADD_SUB;
      ALU_SLL:          alu_funct3 = F3_SLL;
      ALU_SLT:          alu_funct3 = F3_SLT;
      ALU_SLTU:         alu_funct3 = F3_SLTU;
      ALU_XOR:          alu_funct3 = F3_XOR;
      ALU_SRL, ALU_SRA: alu_funct3 = F3_SRL_SRA;
      ALU_OR:           alu_funct3 = F3_OR;
      default:          alu_funct3 = F3_AND;
    endcase
  endfunction

  // funct7[5] selects the alternate form
  function automatic logic alu_alt(input alu_op_t op);
    alu_alt = (op == ALU_SUB) || (op == ALU_SRA);
  endfunction

  function automatic logic alu_is_shift(input alu_op_t op);
    alu_is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/insn_imm_pack.sv
// Immediate range check and scatter into the RV32I immediate bit positions.
// ENC_LI handling only exists when INSN_ENC_PSEUDO_EN is defined.
module insn_imm_pack
  import riscv_pkg::*;
(
  input  enc_op_t     op,
  input  logic        shift,
  input  logic [31:0] imm,
`ifdef INSN_ENC_PSEUDO_EN
  output logic        short_imm,
`endif
  output logic [31:0] field,
  output logic        range_err
);

  logic fits12, fits13, fits21;

  // a value fits N signed bits when every bit from N-1 upward agrees
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

`ifdef INSN_ENC_PSEUDO_EN
  // upper part rounded so that the signed low 12 bits re-add correctly
  logic [19:0] li_hi;
  assign li_hi     = imm[31:12] + {19'b0, imm[11]};
  assign short_imm = fits12;
`endif

  always_comb begin
    field     = '0;
    range_err = 1'b0;
    case (op)
      ENC_I: begin
        if (shift) begin
          field     = {7'b0, imm[4:0], 20'b0};
          range_err = |imm[31:5];
        end else begin
          field     = {imm[11:0], 20'b0};
          range_err = ~fits12;
        end
      end
      ENC_LOAD, ENC_JALR: begin
        field     = {imm[11:0], 20'b0};
        range_err = ~fits12;
      end
      ENC_STORE: begin
        field     = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_err = ~fits12;
      end
      ENC_BRANCH: begin
        field     = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_err = imm[0] | ~fits13;
      end
      ENC_JAL: begin
        field     = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_err = imm[0] | ~fits21;
      end
      ENC_LUI, ENC_AUIPC: begin
        field = {imm[31:12], 12'b0};
      end
`ifdef INSN_ENC_PSEUDO_EN
      ENC_LI: begin
        field = fits12 ? {imm[11:0], 20'b0} : {li_hi, 12'b0};
      end
`endif
      default: range_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// RV32I instruction encoder with valid/ready on both sides and a registered output.
// Define INSN_ENC_PSEUDO_EN to enable the ENC_LI pseudo-op (LUI+ADDI expansion).
module insn_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  enc_op_t     in_op,
  input  alu_op_t     in_alu,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_err
);

`ifdef INSN_ENC_PSEUDO_EN
  typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} state_t;
`else
  typedef enum logic {IDLE = 1'b0} state_t;
`endif

  state_t      state, state_next;
  logic        accept;
  logic [31:0] imm_field;
  logic        range_err;
  logic [31:0] word;
  logic        err;
  logic [2:0]  f3_alu;

  assign f3_alu   = alu_funct3(in_alu);
  assign in_ready = rst_n && (!out_valid || out_ready) && (state == IDLE);
  assign accept   = in_valid && in_ready;

`ifdef INSN_ENC_PSEUDO_EN
  logic        short_imm;
  logic        two_word;
  logic [31:0] lo_word;
  logic [31:0] lo_insn_p1;
`endif

  insn_imm_pack u_imm_pack (
    .op        (in_op),
    .shift     (alu_is_shift(in_alu)),
    .imm       (in_imm),
`ifdef INSN_ENC_PSEUDO_EN
    .short_imm (short_imm),
`endif
    .field     (imm_field),
    .range_err (range_err)
  );

  always_comb begin
    word = '0;
    err  = 1'b0;
`ifdef INSN_ENC_PSEUDO_EN
    two_word = 1'b0;
    lo_word  = {in_imm[11:0], in_rd, 3'b000, in_rd, OPC_OP_IMM};
`endif
    case (in_op)
      ENC_R: word = {1'b0, alu_alt(in_alu), 5'b0, in_rs2, in_rs1, f3_alu, in_rd, OPC_OP};
      ENC_I: begin
        word = imm_field | {1'b0, in_alu == ALU_SRA, 10'b0, in_rs1, f3_alu, in_rd, OPC_OP_IMM};
        err  = range_err || (in_alu == ALU_SUB);
      end
      ENC_LOAD: begin
        word = imm_field | {12'b0, in_rs1, in_funct3, in_rd, OPC_LOAD};
        err  = range_err;
      end
      ENC_STORE: begin
        word = imm_field | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, OPC_STORE};
        err  = range_err;
      end
      ENC_BRANCH: begin
        word = imm_field | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, OPC_BRANCH};
        // funct3 2 and 3 have no branch meaning
        err  = range_err || (in_funct3[2:1] == 2'b01);
      end
      ENC_JAL: begin
        word = imm_field | {20'b0, in_rd, OPC_JAL};
        err  = range_err;
      end
      ENC_JALR: begin
        word = imm_field | {12'b0, in_rs1, F3_JALR, in_rd, OPC_JALR};
        err  = range_err;
      end
      ENC_LUI:   word = imm_field | {20'b0, in_rd, OPC_LUI};
      ENC_AUIPC: word = imm_field | {20'b0, in_rd, OPC_AUIPC};
`ifdef INSN_ENC_PSEUDO_EN
      ENC_LI: begin
        word     = imm_field | {20'b0, in_rd, short_imm ? OPC_OP_IMM : OPC_LUI};
        two_word = !short_imm && (|in_imm[11:0]);
      end
`endif
      default: err = 1'b1;
    endcase
    if (err) word = NOP_INSN;
  end

  always_comb begin
    state_next = state;
`ifdef INSN_ENC_PSEUDO_EN
    case (state)
      IDLE:    if (accept && two_word) state_next = LI_LO;
      LI_LO:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
`else
    state_next = IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // output stage p1: first word on accept, pending ADDI once the LUI is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_insn  <= NOP_INSN;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_insn  <= word;
      out_err   <= err;
`ifdef INSN_ENC_PSEUDO_EN
    end else if (state == LI_LO && out_ready) begin
      out_valid <= 1'b1;
      out_insn  <= lo_insn_p1;
      out_err   <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef INSN_ENC_PSEUDO_EN
  always_ff @(posedge clk) begin
    if (accept && two_word) lo_insn_p1 <= lo_word;
  end
`endif

endmodule
